// File: rtl/mpadder_arbiter.sv
// Round-robin arbiter sharing one registered add/sub unit between two requesters.
// Optional perf counters enabled by defining MPADDER_ARB_PERF_EN.
module mpadder_arbiter #(
  parameter int WIDTH      = 1027,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_sub,
  input  logic [WIDTH:0]   add_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH:0]   rsp_data
`ifdef MPADDER_ARB_PERF_EN
  ,
  output logic [31:0]      perf_issue0,
  output logic [31:0]      perf_issue1,
  output logic [31:0]      perf_stall
`endif
);

  logic                  r_s1_valid;
  logic                  r_s1_id;
  logic                  r_last_grant;
  logic [1:0]            r_count;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [WIDTH:0]        r_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_id;

  logic       w_pop;
  logic [1:0] w_occ;
  logic [1:0] w_left;
  logic       w_can_issue;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_hs0;
  logic       w_hs1;
  logic       w_issue;

  assign rsp_valid = (r_count != 2'd0);
  assign rsp_data  = r_mem[r_rd_ptr];
  assign rsp_id    = r_mem_id[r_rd_ptr];
  assign w_pop     = rsp_valid & rsp_ready;

  // Slots still owed after this cycle's pop: queued plus the in-flight op.
  assign w_occ       = r_count + {1'b0, r_s1_valid};
  assign w_left      = w_occ - {1'b0, w_pop};
  assign w_can_issue = ~reset & (w_left < 2'(FIFO_DEPTH));

  assign w_gnt1 = req1_valid & (~req0_valid | ~r_last_grant);
  assign w_gnt0 = req0_valid & ~w_gnt1;

  assign w_hs0   = w_gnt0 & w_can_issue;
  assign w_hs1   = w_gnt1 & w_can_issue;
  assign w_issue = w_hs0 | w_hs1;

  assign req0_ready = w_hs0;
  assign req1_ready = w_hs1;

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    unique case (1'b1)
      w_hs0: begin
        add_a   = req0_a;
        add_b   = req0_b;
        add_sub = req0_sub;
      end
      w_hs1: begin
        add_a   = req1_a;
        add_b   = req1_b;
        add_sub = req1_sub;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid   <= 1'b0;
      r_s1_id      <= 1'b0;
      r_last_grant <= 1'b1;
      r_count      <= 2'd0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
    end else begin
      r_s1_valid <= w_issue;
      if (w_issue) begin
        r_s1_id      <= w_hs1;
        r_last_grant <= w_hs1;
      end
      if (r_s1_valid) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {1'b0, r_s1_valid} - {1'b0, w_pop};
    end
  end

  // Storage needs no reset; occupancy is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (r_s1_valid) begin
      r_mem[r_wr_ptr]    <= add_result;
      r_mem_id[r_wr_ptr] <= r_s1_id;
    end
  end

`ifdef MPADDER_ARB_PERF_EN
  logic [31:0] r_perf_issue0;
  logic [31:0] r_perf_issue1;
  logic [31:0] r_perf_stall;
  logic        w_stall;

  assign w_stall     = (req0_valid | req1_valid) & ~w_can_issue;
  assign perf_issue0 = r_perf_issue0;
  assign perf_issue1 = r_perf_issue1;
  assign perf_stall  = r_perf_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_issue0 <= '0;
      r_perf_issue1 <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_hs0 && r_perf_issue0 != '1)
        r_perf_issue0 <= r_perf_issue0 + 32'd1;
      if (w_hs1 && r_perf_issue1 != '1)
        r_perf_issue1 <= r_perf_issue1 + 32'd1;
      if (w_stall && r_perf_stall != '1)
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mpadder_arbiter.md
Name: mpadder_arbiter

Overview:
- Shares one pipelined 1027-bit carry-select add/sub unit (mpadder1) between two requesters.
- Round-robin arbitration on valid/ready request ports; the selected operands drive the adder combinationally.
- Tracks the one in-flight operation through the adder's register stage and returns results with a requester ID through a 2-entry output FIFO with backpressure.
- Sits between the Montgomery multiplier/exponentiation control and the shared adder.

Parameters:
- WIDTH, 1027, operand width; result is WIDTH+1 bits.
- FIFO_DEPTH, 2, output FIFO entries; legal values are 2 only.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  WIDTH  operand A
- req0_b  in  WIDTH  operand B
- req0_sub  in  1  1 = A−B, 0 = A+B
- req1_valid, req1_ready, req1_a, req1_b, req1_sub  same as above, requester 1
- add_a  out  WIDTH  to adder in_a
- add_b  out  WIDTH  to adder in_b
- add_sub  out  1  to adder subtract
- add_result  in  WIDTH+1  from adder result, valid 1 cycle after issue
- rsp_valid  out  1  FIFO head valid
- rsp_ready  in  1  consumer accepts the head
- rsp_id  out  1  requester that issued the head
- rsp_data  out  WIDTH+1  result; bit WIDTH is carry for add, not-borrow inverted per adder (1 = borrow) for sub

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk.
  - All state clears: s1_valid=0, FIFO empty, last_grant=1.
  - Consequently rsp_valid=0, req0_ready=0, req1_ready=0, add_a=0, add_b=0, add_sub=0.
  - Reset mid-operation drops the in-flight op and all FIFO entries; no response is produced for them.
- Credit:
  - occ = fifo_count + s1_valid.
  - pop = rsp_valid & rsp_ready.
  - can_issue = (occ − pop) < 2.
  - The adder register stage cannot stall; credit guarantees every issued op has a FIFO slot when it completes.
- Arbitration (combinational, evaluated when can_issue=1):
  - Only one valid: grant it.
  - Both valid: grant the requester ≠ last_grant.
  - reqN_ready = grant==N & can_issue & reqN_valid.
  - At most one ready is high per cycle.
  - can_issue=0: both readies low.
- Issue:
  - On a handshake, add_a/add_b/add_sub = selected requester's operands in the same cycle.
  - Otherwise add_a/add_b/add_sub = 0.
  - On issue: s1_valid←1, s1_id←N, last_grant←N. No issue: s1_valid←0.
- Completion:
  - If s1_valid=1, add_result is pushed into the FIFO at the next edge with id=s1_id.
  - The push is guaranteed to have space; push and pop in the same cycle are both honoured.
- Latency: issue at cycle t → add_result sampled at cycle t+1 → rsp_valid high from cycle t+2 (FIFO registered).
- Throughput: 1 op/cycle sustained while rsp_ready=1.
  - With rsp_ready held 0, at most 2 ops are accepted; then both readies stay 0 until a pop.
- FIFO ordering: strict issue order. rsp_data/rsp_id stable while rsp_valid=1 and rsp_ready=0.
- Request inputs must stay stable while valid and not ready; this block does not check that rule.

Optional Feature:
- MPADDER_ARB_PERF_EN defined:
  - Adds outputs perf_issue0 [31:0] and perf_issue1 [31:0], counting handshakes per requester.
  - Adds perf_stall [31:0], counting cycles with any reqN_valid=1 and can_issue=0.
  - Counters saturate at 0xFFFFFFFF and clear on reset.
- MPADDER_ARB_PERF_EN undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single op: req0 A=5, B=3, sub=0, rsp_ready=1 at cycle 0 → req0_ready at cycle 0; rsp_valid at cycle 2, rsp_id=0, rsp_data=8.
- Subtract with borrow: req1 A=3, B=5, sub=1 → rsp_id=1, rsp_data[1026:0]=2^1027−2, rsp_data[1027]=1.
- Contention: both valid continuously for 6 cycles, rsp_ready=1 → grants 0,1,0,1,0,1; responses in the same order 2 cycles later.
- Backpressure: rsp_ready=0, req0 valid for 4 ops → exactly 2 accepted, then readies stay 0. Raise rsp_ready → one pop per cycle, issue resumes the same cycle as the first pop, all 4 results in order.
- Carry-chain corner: A=all ones (1027 bits), B=1, sub=0 → rsp_data = 1 followed by 1027 zeros (only bit 1027 set).
- Reset mid-flight: issue op, assert reset at cycle 1 → rsp_valid stays 0, no stale response after reset; with MPADDER_ARB_PERF_EN defined, counters read 0.
